// File: rtl/mem_access_ctl_pkg.sv
// Shared definitions for the byte-lane RAM initiator: size codes, FSM states, byte-mask helper.
// Purely declarative; no latency and no flow control of its own.
package mem_access_defs;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_ISSUE1,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  // Size code 3 is handled as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Bits [3:0] are lanes of the first row, bits [7:4] lanes of the following row.
  function automatic logic [7:0] mask(input logic [1:0] o, input logic [2:0] n);
    mask = ((8'd1 << n) - 8'd1) << o;
  endfunction

endpackage

// File: rtl/mem_byte_rotator.sv
// Byte steering between request order and lane order: write rotate-left by 8*offset, read extract.
// Combinational, zero latency; no flow control.
module mem_byte_rotator
  import mem_access_defs::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rot,
  input  logic [63:0] rdata_rows,
  output logic [31:0] rdata
);

  logic [5:0]  shamt;
  logic [31:0] rdata_shift;
  logic [31:0] keep;

  assign shamt       = {1'b0, offset, 3'b000};
  // Low half of the doubled word shifted right by 32-8*o is the left rotate by 8*o.
  assign wdata_rot   = 32'({wdata, wdata} >> (6'd32 - shamt));
  assign rdata_shift = 32'(rdata_rows >> shamt);

  always_comb begin
    case (size)
      SZ_BYTE: keep = 32'h0000_00FF;
      SZ_HALF: keep = 32'h0000_FFFF;
      default: keep = 32'hFFFF_FFFF;
    endcase
  end

  assign rdata = rdata_shift & keep;

endmodule

// File: rtl/mem_access_ctl.sv
// Byte-addressed load/store to four 8-bit RAM lanes, splitting row-crossing accesses in two.
// Latency T+2..T+4 accept-to-response; req_ready low while busy, response cannot be stalled.
module mem_access_ctl
  import mem_access_defs::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] lane_addr,
  output logic [31:0]           lane_din,
  output logic [3:0]            lane_we,
  input  logic [31:0]           lane_dout
);

  state_t                state;
  logic                  r_we;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_row;
  logic [31:0]           r_wdata;
  logic [7:0]            r_mask;
  logic [31:0]           row_lat;
  logic [3:0]            we_q;

  logic [7:0]  req_mask;
  logic        split;
  logic [63:0] rows;
  logic [31:0] rd_extract;

  assign req_mask = mask(req_addr[1:0], size_bytes(req_size));
  assign split    = |r_mask[7:4];
  // Non-split loads only see one row; its data sits in the low half.
  assign rows     = split ? {lane_dout, row_lat} : {32'd0, lane_dout};

  mem_byte_rotator u_rot (
    .offset     (r_off),
    .size       (r_size),
    .wdata      (r_wdata),
    .wdata_rot  (lane_din),
    .rdata_rows (rows),
    .rdata      (rd_extract)
  );

  // Gating keeps a reset cycle from finishing a write already set up in we_q.
  assign lane_we = we_q & {4{~reset}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      lane_addr <= '0;
      we_q      <= 4'd0;
      r_we      <= 1'b0;
      r_off     <= 2'd0;
      r_size    <= 2'd0;
      r_row     <= '0;
      r_wdata   <= 32'd0;
      r_mask    <= 8'd0;
      row_lat   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_off     <= req_addr[1:0];
            r_size    <= req_size;
            r_row     <= req_addr[ADDR_WIDTH+1:2];
            r_wdata   <= req_wdata;
            r_mask    <= req_mask;
            lane_addr <= req_addr[ADDR_WIDTH+1:2];
            we_q      <= req_we ? req_mask[3:0] : 4'd0;
            req_ready <= 1'b0;
            state     <= ST_ISSUE0;
          end
        end
        ST_ISSUE0: begin
          if (split) begin
            lane_addr <= r_row + 1'b1;
            we_q      <= r_we ? r_mask[7:4] : 4'd0;
            state     <= ST_ISSUE1;
          end else if (!r_we) begin
            we_q  <= 4'd0;
            state <= ST_CAPTURE;
          end else begin
            we_q      <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= ST_RESP;
          end
        end
        ST_ISSUE1: begin
          we_q <= 4'd0;
          if (!r_we) begin
            row_lat <= lane_dout;
            state   <= ST_CAPTURE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= ST_RESP;
          end
        end
        ST_CAPTURE: begin
          rsp_rdata <= rd_extract;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          we_q      <= 4'd0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Bench for mem_access_ctl: lane RAM model plus byte-array reference, directed and random traffic.
// Small row space so the top-row wrap is exercised often.
module tb_mem_access_ctl;

  localparam int AW = 4;
  localparam int BA = AW + 2;
  localparam int NB = 1 << BA;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [BA-1:0] req_addr;
  logic [1:0]    req_size;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] lane_addr;
  logic [31:0]   lane_din;
  logic [3:0]    lane_we;
  logic [31:0]   lane_dout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctl #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .lane_addr (lane_addr),
    .lane_din  (lane_din),
    .lane_we   (lane_we),
    .lane_dout (lane_dout)
  );

  // Four lane RAMs, registered read address, read-old-data.
  logic       mem_clear;
  logic [7:0] lane_mem [4][1<<AW];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int l = 0; l < 4; l++)
        for (int r = 0; r < (1<<AW); r++)
          lane_mem[l][r] <= 8'd0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (lane_we[l]) lane_mem[l][lane_addr] <= lane_din[8*l +: 8];
    end
    lane_dout <= {lane_mem[3][lane_addr], lane_mem[2][lane_addr],
                  lane_mem[1][lane_addr], lane_mem[0][lane_addr]};
  end

  // Reference: flat byte memory, byte address wraps modulo the whole space.
  logic [7:0] ref_mem [NB];

  logic [AW-1:0] rec_addr [16];
  logic [3:0]    rec_we   [16];
  logic [31:0]   rec_din  [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic do_req(input logic we, input logic [BA-1:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int  cnt;
    bit  load_we_seen;
    @(negedge clk);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    load_we_seen = 1'b0;
    while (cnt < 12) begin
      rec_addr[cnt] = lane_addr;
      rec_we[cnt]   = lane_we;
      rec_din[cnt]  = lane_din;
      if (!we && lane_we != 4'd0) load_we_seen = 1'b1;
      if (rsp_valid) break;
      @(negedge clk);
      cnt++;
    end
    lat = cnt;
    rd  = rsp_rdata;
    @(negedge clk);
    chk("rsp_single_pulse", 64'(rsp_valid), 64'd0);
    chk("ready_after_rsp", 64'(req_ready), 64'd1);
    if (!we) chk("load_no_we", 64'(load_we_seen), 64'd0);
  endtask

  // Runs one request and checks latency and data against the reference rules.
  task automatic txn(input logic we, input logic [BA-1:0] a, input logic [1:0] sz,
                     input logic [31:0] wd, output logic [31:0] rd);
    int          n;
    int          exp_lat;
    int          lat;
    logic [31:0] exp_rd;
    n = nbytes(sz);
    exp_lat = 2 + ((int'(a[1:0]) + n > 4) ? 1 : 0) + (we ? 0 : 1);
    exp_rd = 32'd0;
    if (!we)
      for (int k = 0; k < n; k++)
        exp_rd[8*k +: 8] = ref_mem[(int'(a) + k) % NB];
    do_req(we, a, sz, wd, rd, lat);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk(we ? "store_rdata_zero" : "load_rdata", 64'(rd), 64'(exp_rd));
    if (we)
      for (int k = 0; k < n; k++)
        ref_mem[(int'(a) + k) % NB] = wd[8*k +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    bit          rsp_seen;
    reset     = 1'b1;
    mem_clear = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_size  = 2'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_lane_we", 64'(lane_we), 64'd0);
    chk("rst_lane_addr", 64'(lane_addr), 64'd0);
    reset = 1'b0;
    mem_clear = 1'b0;

    // 1: reset for two cycles while idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'd1);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1_lane_we", 64'(lane_we), 64'd0);
    reset = 1'b0;

    // 2: aligned word
    txn(1'b1, 6'h10, 2'd2, 32'hDEADBEEF, rd);
    chk("t2_st_addr", 64'(rec_addr[1]), 64'd4);
    chk("t2_st_we", 64'(rec_we[1]), 64'hF);
    txn(1'b0, 6'h10, 2'd2, 32'd0, rd);
    chk("t2_ld_data", 64'(rd), 64'hDEADBEEF);

    // 3: byte in lane 3
    txn(1'b1, 6'h13, 2'd0, 32'h000000A5, rd);
    chk("t3_st_we", 64'(rec_we[1]), 64'h8);
    chk("t3_st_din", 64'(rec_din[1][31:24]), 64'hA5);
    txn(1'b0, 6'h13, 2'd0, 32'd0, rd);
    chk("t3_ld_data", 64'(rd), 64'hA5);

    // 4: word crossing rows 3/4
    txn(1'b1, 6'h0E, 2'd2, 32'h11223344, rd);
    chk("t4_c1_addr", 64'(rec_addr[1]), 64'd3);
    chk("t4_c1_we", 64'(rec_we[1]), 64'hC);
    chk("t4_c1_din", 64'(rec_din[1][31:16]), 64'h3344);
    chk("t4_c2_addr", 64'(rec_addr[2]), 64'd4);
    chk("t4_c2_we", 64'(rec_we[2]), 64'h3);
    chk("t4_c2_din", 64'(rec_din[2][15:0]), 64'h1122);
    txn(1'b0, 6'h0E, 2'd2, 32'd0, rd);
    chk("t4_ld_data", 64'(rd), 64'h11223344);

    // 5: half crossing the top row into row 0
    txn(1'b1, 6'h3F, 2'd1, 32'h0000BEEF, rd);
    chk("t5_c1_addr", 64'(rec_addr[1]), 64'd15);
    chk("t5_c1_we", 64'(rec_we[1]), 64'h8);
    chk("t5_c2_addr", 64'(rec_addr[2]), 64'd0);
    chk("t5_c2_we", 64'(rec_we[2]), 64'h1);
    txn(1'b0, 6'h3F, 2'd1, 32'd0, rd);
    chk("t5_ld_data", 64'(rd), 64'h0000BEEF);

    // 6: reset during the second row of a split store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 6'h0E;
    req_size  = 2'd2;
    req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_issue0_we", 64'(lane_we), 64'hC);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_issue1_we_gated", 64'(lane_we), 64'h0);
    ref_mem[6'h0E] = 8'h0D;
    ref_mem[6'h0F] = 8'hF0;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_ready", 64'(req_ready), 64'd1);
    rsp_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rsp_seen = 1'b1;
      @(negedge clk);
    end
    chk("t6_no_rsp", 64'(rsp_seen), 64'd0);
    txn(1'b0, 6'h0E, 2'd2, 32'd0, rd);
    chk("t6_ld_partial", 64'(rd), 64'h1122F00D);

    // Random mix against the reference
    for (int i = 0; i < 300; i++) begin
      txn(1'($urandom_range(0, 1)), BA'($urandom_range(0, NB-1)),
          2'($urandom_range(0, 3)), $urandom, rd);
    end

    for (int a = 0; a < NB; a++)
      chk("final_mem", 64'(lane_mem[a % 4][a / 4]), 64'(ref_mem[a]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
